// File: rtl/adc_channel_scheduler.sv
// Round-robin ADC channel scheduler: per slot select mux/relay/coupling, settle, then capture a tagged burst.
// Latency: 1 register stage on sample data; no backpressure -- the ADC cannot stall, so drops set sticky O_overflow.
module adc_channel_scheduler #(
    parameter int DATA_W        = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int BURST_LEN     = 256
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              I_enable,
    input  logic [3:0]        I_ch_mask,
    input  logic [3:0]        I_relay_cfg,
    input  logic [3:0]        I_coupling_cfg,
    input  logic [DATA_W-1:0] I_AD_Data,
    input  logic              I_OTR,
    input  logic              I_sample_ready,
    input  logic              I_clr_ovf,
    output logic              O_S0,
    output logic              O_S1,
    output logic              O_relay,
    output logic              O_AC_DC_coupling,
    output logic [DATA_W-1:0] O_sample_data,
    output logic              O_sample_otr,
    output logic [1:0]        O_sample_ch,
    output logic              O_sample_valid,
    output logic              O_burst_last,
    output logic              O_busy,
    output logic              O_overflow
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_NEXT
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  ptr;
    logic [1:0]  ch;
    logic [1:0]  pick_ch;
    logic        pick_vld;
    logic [7:0]  settle_cnt;
    logic [15:0] burst_cnt;
    logic        settle_done;
    logic        burst_done;

    assign settle_done = (settle_cnt == 8'(SETTLE_CYCLES - 1));
    assign burst_done  = (burst_cnt == 16'(BURST_LEN - 1));
    assign O_S0        = ch[0];
    assign O_S1        = ch[1];

    // Scan downward so the enabled channel closest to ptr is the one left standing.
    always_comb begin
        logic [1:0] idx;
        idx      = ptr;
        pick_vld = 1'b0;
        pick_ch  = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (I_ch_mask[idx]) begin
                pick_vld = 1'b1;
                pick_ch  = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (I_enable && (I_ch_mask != 4'b0000)) state_nxt = ST_SELECT;
            ST_SELECT:  state_nxt = pick_vld ? ST_SETTLE : ST_IDLE;
            ST_SETTLE:  if (settle_done) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (burst_done) state_nxt = ST_NEXT;
            ST_NEXT:    state_nxt = I_enable ? ST_SELECT : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ptr              <= 2'd0;
            ch               <= 2'd0;
            O_relay          <= 1'b0;
            O_AC_DC_coupling <= 1'b0;
            settle_cnt       <= 8'd0;
            burst_cnt        <= 16'd0;
            O_sample_data    <= '0;
            O_sample_otr     <= 1'b0;
            O_sample_ch      <= 2'd0;
            O_sample_valid   <= 1'b0;
            O_burst_last     <= 1'b0;
            O_busy           <= 1'b0;
            O_overflow       <= 1'b0;
        end else begin
            case (state)
                ST_SELECT: begin
                    settle_cnt <= 8'd0;
                    if (pick_vld) begin
                        ch               <= pick_ch;
                        O_relay          <= I_relay_cfg[pick_ch];
                        O_AC_DC_coupling <= I_coupling_cfg[pick_ch];
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    burst_cnt  <= 16'd0;
                end
                ST_CAPTURE: begin
                    burst_cnt     <= burst_cnt + 16'd1;
                    O_sample_data <= I_AD_Data;
                    O_sample_otr  <= I_OTR;
                    O_sample_ch   <= ch;
                end
                ST_NEXT: ptr <= ch + 2'd1;
                default: ;
            endcase
            O_sample_valid <= (state == ST_CAPTURE);
            O_burst_last   <= (state == ST_CAPTURE) && burst_done;
            O_busy         <= (state_nxt != ST_IDLE);
            // A drop in the same cycle as a clear must stay visible.
            O_overflow     <= (O_sample_valid && !I_sample_ready) || (O_overflow && !I_clr_ovf);
        end
    end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench for adc_channel_scheduler: slot order, config routing, timing, overflow, enable/mask/reset cases.
module tb_adc_channel_scheduler;
    localparam int DATA_W = 10;
    localparam int SETTLE = 16;
    localparam int BURST  = 256;
    localparam int SLOT   = SETTLE + BURST + 2;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              I_enable;
    logic [3:0]        I_ch_mask;
    logic [3:0]        I_relay_cfg;
    logic [3:0]        I_coupling_cfg;
    logic [DATA_W-1:0] I_AD_Data;
    logic              I_OTR;
    logic              I_sample_ready;
    logic              I_clr_ovf;
    logic              O_S0, O_S1, O_relay, O_AC_DC_coupling;
    logic [DATA_W-1:0] O_sample_data;
    logic              O_sample_otr;
    logic [1:0]        O_sample_ch;
    logic              O_sample_valid, O_burst_last, O_busy, O_overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int tf    = 0;
    int tprev = 0;
    int wn    = 0;

    adc_channel_scheduler #(.DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE), .BURST_LEN(BURST)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .I_enable(I_enable), .I_ch_mask(I_ch_mask),
        .I_relay_cfg(I_relay_cfg), .I_coupling_cfg(I_coupling_cfg), .I_AD_Data(I_AD_Data),
        .I_OTR(I_OTR), .I_sample_ready(I_sample_ready), .I_clr_ovf(I_clr_ovf),
        .O_S0(O_S0), .O_S1(O_S1), .O_relay(O_relay), .O_AC_DC_coupling(O_AC_DC_coupling),
        .O_sample_data(O_sample_data), .O_sample_otr(O_sample_otr), .O_sample_ch(O_sample_ch),
        .O_sample_valid(O_sample_valid), .O_burst_last(O_burst_last), .O_busy(O_busy),
        .O_overflow(O_overflow)
    );

    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs driven on the falling edge; data is a ramp, OTR pulses every 37 cycles.
    task automatic tick();
        @(negedge Clk);
        cyc++;
        I_AD_Data = DATA_W'(cyc);
        I_OTR     = ((cyc % 37) == 0);
    endtask

    task automatic check_reset();
        chk("rst_s0", O_S0, 0);
        chk("rst_s1", O_S1, 0);
        chk("rst_relay", O_relay, 0);
        chk("rst_coup", O_AC_DC_coupling, 0);
        chk("rst_data", O_sample_data, 0);
        chk("rst_otr", O_sample_otr, 0);
        chk("rst_ch", O_sample_ch, 0);
        chk("rst_valid", O_sample_valid, 0);
        chk("rst_last", O_burst_last, 0);
        chk("rst_busy", O_busy, 0);
        chk("rst_ovf", O_overflow, 0);
    endtask

    task automatic slot(input logic [1:0] ech, input logic erel, input logic ecoup,
                        input int drop_at, input int clr_at, input int dis_at,
                        input int mask_at, input logic [3:0] new_mask, input logic clr_with_drop,
                        output int t_first);
        int waitn = 0, n = 0, lasts = 0, last_idx = -1, t_mux = -1;
        int bad_tag = 0, bad_dat = 0, bad_otr = 0;
        logic [1:0] pm;
        pm = {O_S1, O_S0};
        while (!O_sample_valid && waitn < 2 * SLOT) begin
            tick();
            waitn++;
            if ({O_S1, O_S0} !== pm) begin
                t_mux = cyc;
                pm    = {O_S1, O_S0};
            end
        end
        t_first = cyc;
        chk("valid_seen", O_sample_valid, 1);
        chk("mux", {O_S1, O_S0}, ech);
        chk("relay", O_relay, erel);
        chk("coupling", O_AC_DC_coupling, ecoup);
        chk("busy_run", O_busy, 1);
        if (t_mux >= 0) chk("settle_lat", t_first - t_mux, SETTLE + 1);
        while (O_sample_valid && n < BURST + 8) begin
            if (O_sample_ch !== ech) bad_tag++;
            if (O_sample_data !== DATA_W'(cyc - 1)) bad_dat++;
            if (O_sample_otr !== (((cyc - 1) % 37) == 0)) bad_otr++;
            if (O_burst_last === 1'b1) begin
                lasts++;
                last_idx = n;
            end
            if (drop_at >= 0 && n == drop_at + 1) chk("ovf_set", O_overflow, 1);
            if (drop_at >= 0 && n == drop_at + 6) chk("ovf_sticky", O_overflow, 1);
            if (clr_at >= 0 && n == clr_at + 1) chk("ovf_clr", O_overflow, 0);
            I_sample_ready = (n != drop_at);
            I_clr_ovf      = (n == clr_at) || (clr_with_drop && n == drop_at);
            if (n == dis_at) I_enable = 1'b0;
            if (n == mask_at) I_ch_mask = new_mask;
            tick();
            n++;
        end
        I_sample_ready = 1'b1;
        I_clr_ovf      = 1'b0;
        chk("burst_cnt", n, BURST);
        chk("last_cnt", lasts, 1);
        chk("last_pos", last_idx, BURST - 1);
        chk("tag_err", bad_tag, 0);
        chk("data_err", bad_dat, 0);
        chk("otr_err", bad_otr, 0);
        chk("mux_hold", {O_S1, O_S0}, ech);
    endtask

    initial begin
        Rst_n = 1'b0; I_enable = 1'b0; I_ch_mask = 4'b0000; I_relay_cfg = 4'b0000;
        I_coupling_cfg = 4'b0000; I_AD_Data = '0; I_OTR = 1'b0; I_sample_ready = 1'b1;
        I_clr_ovf = 1'b0;
        repeat (3) tick();
        check_reset();
        Rst_n = 1'b1;
        tick();
        chk("idle_busy", O_busy, 0);

        // All four channels in rotation, default settle/burst.
        I_ch_mask = 4'b1111;
        I_enable  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            slot(2'(k % 4), 1'b0, 1'b0, -1, -1, -1, -1, 4'b0000, 1'b0, tf);
            if (k > 0) chk("period", tf - tprev, SLOT);
            tprev = tf;
        end
        chk("no_ovf", O_overflow, 0);

        // Sparse mask with per-channel relay/coupling; overflow handling on the third slot.
        I_ch_mask = 4'b1010; I_relay_cfg = 4'b0010; I_coupling_cfg = 4'b1000;
        slot(2'd1, 1'b1, 1'b0, -1, -1, -1, -1, 4'b0000, 1'b0, tf);
        tprev = tf;
        slot(2'd3, 1'b0, 1'b1, -1, -1, -1, -1, 4'b0000, 1'b0, tf);
        chk("period_13", tf - tprev, SLOT);
        tprev = tf;
        slot(2'd1, 1'b1, 1'b0, 40, 120, -1, -1, 4'b0000, 1'b1, tf);
        chk("period_31", tf - tprev, SLOT);
        slot(2'd3, 1'b0, 1'b1, -1, -1, -1, -1, 4'b0000, 1'b0, tf);

        // Enable dropped mid-burst on ch2; burst completes, then idle; pointer survives.
        I_ch_mask = 4'b0100;
        slot(2'd2, 1'b0, 1'b0, -1, -1, 100, -1, 4'b0000, 1'b0, tf);
        chk("dis_busy", O_busy, 0);
        repeat (5) tick();
        chk("dis_busy_hold", O_busy, 0);
        chk("dis_valid", O_sample_valid, 0);
        I_ch_mask = 4'b1111;
        I_enable  = 1'b1;
        slot(2'd3, 1'b0, 1'b1, -1, -1, -1, -1, 4'b0000, 1'b0, tf);

        // Mask emptied mid-burst: SELECT falls back to IDLE with outputs held.
        I_ch_mask = 4'b0001;
        slot(2'd0, 1'b0, 1'b0, -1, -1, -1, 50, 4'b0000, 1'b0, tf);
        chk("empty_sel_busy", O_busy, 1);
        tick();
        chk("empty_busy", O_busy, 0);
        chk("empty_mux", {O_S1, O_S0}, 0);
        chk("empty_coup", O_AC_DC_coupling, 0);
        repeat (4) tick();
        chk("empty_valid", O_sample_valid, 0);

        // Reset in the middle of a ch1 burst.
        I_ch_mask = 4'b0010;
        wn = 0;
        while (!O_sample_valid && wn < 2 * SLOT) begin
            tick();
            wn++;
        end
        repeat (10) tick();
        chk("pre_rst_valid", O_sample_valid, 1);
        chk("pre_rst_relay", O_relay, 1);
        chk("pre_rst_mux", {O_S1, O_S0}, 1);
        Rst_n = 1'b0;
        tick();
        check_reset();
        Rst_n    = 1'b1;
        I_enable = 1'b0;
        repeat (2) tick();
        chk("post_rst_valid", O_sample_valid, 0);

        // Pointer returns to 0 after reset.
        I_ch_mask = 4'b1111;
        I_enable  = 1'b1;
        slot(2'd0, 1'b0, 1'b0, -1, -1, -1, -1, 4'b0000, 1'b0, tf);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
